// File: rtl/ins_cache_ctrl_if.sv
// Bus bundle for the Core101 instruction cache controller: fetch request and
// response, data array port, burst memory port and performance counters.
// The slave modport is the controller side, master is the surrounding system.
interface ins_cache_ctrl_if;
  logic        req_valid_in;
  logic [31:0] req_addr_in;
  logic        req_ready_out;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;
  logic        flush_in;
  logic [9:0]  darr_addr_out;
  logic        darr_we_out;
  logic [31:0] darr_wdata_out;
  logic [31:0] darr_rdata_in;
  logic        mem_req_valid_out;
  logic [31:0] mem_req_addr_out;
  logic        mem_req_ready_in;
  logic        mem_resp_valid_in;
  logic [31:0] mem_resp_data_in;
  logic [31:0] hit_count_out;
  logic [31:0] miss_count_out;

  modport slave (
    input  req_valid_in, req_addr_in, flush_in, darr_rdata_in,
           mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    output req_ready_out, resp_valid_out, resp_data_out, darr_addr_out,
           darr_we_out, darr_wdata_out, mem_req_valid_out, mem_req_addr_out,
           hit_count_out, miss_count_out
  );

  modport master (
    output req_valid_in, req_addr_in, flush_in, darr_rdata_in,
           mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    input  req_ready_out, resp_valid_out, resp_data_out, darr_addr_out,
           darr_we_out, darr_wdata_out, mem_req_valid_out, mem_req_addr_out,
           hit_count_out, miss_count_out
  );
endinterface

// File: rtl/ins_cache_ctrl.sv
// Refill/lookup controller for the Core101 direct-mapped instruction cache
// (256 lines x 4 words, 20-bit tag). Tags and valid bits live in flops, the
// data words in an external synchronous-read array.
// Optional hit/miss counters: define INS_CACHE_CTRL_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a fetch; presents request address to data array
// LOOKUP   | compare tag; on hit return array data this cycle
// MISS_REQ | hold line request on the memory port until accepted
// REFILL   | write the 4 incoming beats, capture the requested word
// RESP     | return the captured critical word
// FLUSH    | clear all valid bits
module ins_cache_ctrl (
  input logic             ins_cache_ctrl_clock_in,
  input logic             ins_cache_ctrl_reset_in,
  ins_cache_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL   = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;

  logic [2:0]   state, state_nxt;
  logic [19:0]  lat_tag;
  logic [7:0]   lat_index;
  logic [1:0]   lat_off;
  logic [1:0]   beat;
  logic [31:0]  crit_word;
  logic [255:0] valid;
  logic [19:0]  tag_mem [256];
  logic         accept, hit, beat_in, last_beat;
  logic         unused_addr_bits;

  // byte-offset bits never matter for word fetches
  assign unused_addr_bits = ^bus.req_addr_in[1:0];

  assign accept    = (state == S_IDLE) && !bus.flush_in && bus.req_valid_in;
  assign hit       = valid[lat_index] && (tag_mem[lat_index] == lat_tag);
  assign beat_in   = (state == S_REFILL) && bus.mem_resp_valid_in;
  assign last_beat = beat_in && (beat == 2'd3);

  assign bus.mem_req_addr_out = {lat_tag, lat_index, 4'b0000};

  // next state and all handshake/array outputs
  always_comb begin
    state_nxt              = state;
    bus.req_ready_out      = 1'b0;
    bus.resp_valid_out     = 1'b0;
    bus.resp_data_out      = 32'd0;
    bus.darr_addr_out      = {lat_index, lat_off};
    bus.darr_we_out        = 1'b0;
    bus.darr_wdata_out     = 32'd0;
    bus.mem_req_valid_out  = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready_out = !bus.flush_in;
        if (bus.flush_in) begin
          state_nxt = S_FLUSH;
        end else if (bus.req_valid_in) begin
          bus.darr_addr_out = bus.req_addr_in[11:2];
          state_nxt         = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          bus.resp_valid_out = 1'b1;
          bus.resp_data_out  = bus.darr_rdata_in;
          state_nxt          = S_IDLE;
        end else begin
          state_nxt = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        bus.mem_req_valid_out = 1'b1;
        if (bus.mem_req_ready_in) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        bus.darr_addr_out = {lat_index, beat};
        if (bus.mem_resp_valid_in) begin
          bus.darr_we_out    = 1'b1;
          bus.darr_wdata_out = bus.mem_resp_data_in;
          if (beat == 2'd3) state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        bus.resp_valid_out = 1'b1;
        bus.resp_data_out  = crit_word;
        state_nxt          = S_IDLE;
      end
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge ins_cache_ctrl_clock_in or negedge ins_cache_ctrl_reset_in) begin
    if (!ins_cache_ctrl_reset_in) state <= S_IDLE;
    else                          state <= state_nxt;
  end

  // latch the accepted request address
  always_ff @(posedge ins_cache_ctrl_clock_in or negedge ins_cache_ctrl_reset_in) begin
    if (!ins_cache_ctrl_reset_in) begin
      lat_tag   <= 20'd0;
      lat_index <= 8'd0;
      lat_off   <= 2'd0;
    end else if (accept) begin
      lat_tag   <= bus.req_addr_in[31:12];
      lat_index <= bus.req_addr_in[11:4];
      lat_off   <= bus.req_addr_in[3:2];
    end
  end

  // beat counter and critical-word capture during refill
  always_ff @(posedge ins_cache_ctrl_clock_in or negedge ins_cache_ctrl_reset_in) begin
    if (!ins_cache_ctrl_reset_in) begin
      beat      <= 2'd0;
      crit_word <= 32'd0;
    end else begin
      if ((state == S_MISS_REQ) && bus.mem_req_ready_in) beat <= 2'd0;
      else if (beat_in)                                   beat <= beat + 2'd1;
      if (beat_in && (beat == lat_off)) crit_word <= bus.mem_resp_data_in;
    end
  end

  // valid bits: set on refill completion, cleared by flush and reset
  always_ff @(posedge ins_cache_ctrl_clock_in or negedge ins_cache_ctrl_reset_in) begin
    if (!ins_cache_ctrl_reset_in)  valid <= '0;
    else if (state == S_FLUSH)     valid <= '0;
    else if (last_beat)            valid[lat_index] <= 1'b1;
  end

  // tag store is deliberately not reset; valid bits gate its use
  always_ff @(posedge ins_cache_ctrl_clock_in) begin
    if (last_beat) tag_mem[lat_index] <= lat_tag;
  end

`ifdef INS_CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;

  // saturating hit/miss counters, cleared only by reset
  always_ff @(posedge ins_cache_ctrl_clock_in or negedge ins_cache_ctrl_reset_in) begin
    if (!ins_cache_ctrl_reset_in) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign bus.hit_count_out  = hit_cnt;
  assign bus.miss_count_out = miss_cnt;
`else
  assign bus.hit_count_out  = 32'd0;
  assign bus.miss_count_out = 32'd0;
`endif

endmodule

// File: doc/ins_cache_ctrl.md
# ins_cache_ctrl

Refill and lookup controller for the Core101 direct-mapped instruction cache: 256 lines × 4 words × 32 bit, 20-bit tag, 8-bit index, 2-bit word offset. It accepts fetch requests from the fetch stage and holds the tag and valid state in flops. It serves hits from the external data array, and on a miss fetches the whole line over a burst memory port, writes it into the data array and returns the requested word.

## Interface
- No parameters; geometry is fixed. Address split: tag = addr[31:12], index = addr[11:4], offset = addr[3:2], addr[1:0] ignored.
- ins_cache_ctrl_clock_in  in  1  clock; all state updates on the rising edge.
- ins_cache_ctrl_reset_in  in  1  asynchronous, active-low reset.
- req_valid_in  in  1  fetch request valid.
- req_addr_in  in  32  fetch byte address.
- req_ready_out  out  1  request accepted when high together with req_valid_in.
- resp_valid_out  out  1  one-cycle pulse; resp_data_out is valid. The core always accepts it.
- resp_data_out  out  32  fetched instruction word.
- flush_in  in  1  invalidate all lines; level, sampled in IDLE.
- darr_addr_out  out  10  data array word address {index, offset}.
- darr_we_out  out  1  data array write enable.
- darr_wdata_out  out  32  data array write data.
- darr_rdata_in  in  32  data array read data; synchronous read, valid the cycle after the address.
- mem_req_valid_out  out  1  line fetch request.
- mem_req_addr_out  out  32  line-aligned address {tag, index, 4'b0}.
- mem_req_ready_in  in  1  memory accepts the request.
- mem_resp_valid_in  in  1  refill beat valid; exactly 4 beats per request, ascending word order.
- mem_resp_data_in  in  32  refill beat data.
- hit_count_out  out  32  hit counter; see Configuration.
- miss_count_out  out  32  miss counter; see Configuration.

## Operation
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH.
- **IDLE**
  - req_ready_out = 1, except when flush_in = 1.
  - flush_in = 1 → FLUSH. Flush wins over a simultaneous request; the request is not accepted.
  - Request handshake: latch req_addr_in, drive darr_addr_out = {index, offset} → LOOKUP.
- **LOOKUP**
  - req_ready_out = 0.
  - Hit (valid[index] && tag[index] == latched tag): resp_valid_out = 1, resp_data_out = darr_rdata_in → IDLE.
  - Otherwise → MISS_REQ.
- **MISS_REQ**
  - mem_req_valid_out = 1 with a stable address until mem_req_ready_in = 1; then clear the beat counter → REFILL.
- **REFILL**
  - On each mem_resp_valid_in: darr_we_out = 1, darr_addr_out = {index, beat}, darr_wdata_out = mem_resp_data_in.
  - When beat == latched offset, capture the beat into the critical-word register.
  - Beat counter is 2 bits. On beat 3: write tag[index] = latched tag, set valid[index] → RESP.
  - mem_resp_valid_in is ignored in every state except REFILL.
- **RESP**: resp_valid_out = 1, resp_data_out = critical-word register → IDLE.
- **FLUSH**: clear all 256 valid bits in one cycle → IDLE. A flush_in asserted outside IDLE takes effect on the next IDLE cycle.
- darr_we_out is asserted only in REFILL.
- darr_addr_out holds the latched {index, offset} in all states other than IDLE and REFILL.
- Tags are not reset; only valid bits are.

## Timing
- Reset values:
  - state = IDLE, all valid bits = 0, beat counter = 0.
  - req_ready_out = 1, resp_valid_out = 0, resp_data_out = 0, darr_we_out = 0, darr_addr_out = 0, darr_wdata_out = 0, mem_req_valid_out = 0, mem_req_addr_out = 0.
  - Counters = 0.
- Hit: request accepted at cycle N, response at N+1. Maximum throughput is one hit per 2 cycles.
- Miss: if mem_req_ready_in is high at entry, the request is accepted at N+2. The response comes one cycle after the edge that writes the 4th beat.
- Beats may have gaps; the controller waits indefinitely.
- Reset asserted mid-refill:
  - Immediate return to IDLE; the partial line stays invalid.
  - The memory side must drop the outstanding burst. Stray beats are ignored because the controller is not in REFILL.
- A refilled line is a hit on the next request to the same line.

## Configuration
- INS_CACHE_CTRL_PERF_EN defined:
  - hit_count_out increments on each LOOKUP hit.
  - miss_count_out increments on each LOOKUP → MISS_REQ transition.
  - Both counters are 32-bit and saturate at 0xFFFF_FFFF.
  - Both clear on reset and are not cleared by flush.
- Undefined: the counter registers are omitted and both ports are tied to 0.

## Test plan
- Cold miss: after reset, request 0x0000_1008; memory returns beats 0xA0..0xA3.
  - Required: mem_req_addr_out = 0x0000_1000, four darr writes to addresses 0x000–0x003 with data 0xA0..0xA3, resp_data_out = 0xA2.
  - With PERF: miss_count_out = 1.
- Hit after refill: request 0x0000_100C → resp_data_out = 0xA3 exactly one cycle after acceptance, no mem_req_valid_out, hit_count_out = 1 (PERF).
- Conflict: request 0x0000_2008 (same index 0x00, tag 0x2) → miss and refill; then re-request 0x0000_1008 → miss again.
- Flush: assert flush_in together with req_valid_in in IDLE.
  - Required: req_ready_out = 0 that cycle and FLUSH entered; the subsequent request to 0x0000_1008 misses.
- Stalled memory and reset:
  - Hold mem_req_ready_in low for 5 cycles → mem_req_valid_out and mem_req_addr_out stay stable.
  - Assert reset after beat 2 → IDLE, req_ready_out = 1; a re-request to the same line misses.
- Gapped beats: beats spaced 3 cycles apart → exactly 4 darr writes; response one cycle after the last write.
